wb_pipe: RTL and testbench
==========================

WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter RADDR, default 5, register-address width.
REQ-003 Parameter CNTW, default 32, retire-counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  MEM/WB instruction present.
REQ-007 in_ready  out  1  stage can accept an instruction.
REQ-008 wb_sel  in  2  result source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
REQ-009 ld_size  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only).
REQ-010 ld_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
REQ-011 reg_write  in  1  instruction writes rd.
REQ-012 rd  in  RADDR  destination register.
REQ-013 alu_result  in  XLEN  ALU result; also the load address, low OFFW=log2(XLEN/8) bits give byte offset.
REQ-014 pc_plus4  in  XLEN  link value.
REQ-015 imm  in  XLEN  immediate value.
REQ-016 mem_rvalid  in  1  load data valid.
REQ-017 mem_rdata  in  XLEN  load data word.
REQ-018 flush  in  1  kill the current or incoming instruction.
REQ-019 rf_we  out  1  register-file write enable.
REQ-020 rf_waddr  out  RADDR  write address.
REQ-021 rf_wdata  out  XLEN  write data.
REQ-022 busy  out  1  load outstanding.
REQ-023 retire_cnt  out  CNTW  count of completed instructions.

Function
REQ-024 FSM states: IDLE, WAIT_MEM; in_ready = (state==IDLE); busy = (state==WAIT_MEM).
REQ-025 Accept = in_valid & in_ready & ~flush; flush with in_valid in IDLE drops the instruction, with no write and no count.
REQ-026 Accepted non-MEM instruction: selected source is registered; rf_we, rf_waddr and rf_wdata are valid on the next cycle; back-to-back issue every cycle is supported.
REQ-027 Accepted MEM instruction: capture rd, reg_write, ld_size, ld_unsigned and offset, then go to WAIT_MEM; mem_rvalid is ignored outside WAIT_MEM.
REQ-028 In WAIT_MEM with mem_rvalid & ~flush: aligned, extended data is written with one-cycle latency (rf_we high the cycle after mem_rvalid); state returns to IDLE on the same edge.
REQ-029 Load alignment: byte uses lane=offset; half uses lane=offset[OFFW-1:1]; word uses lane=offset[OFFW-1:2] (selects the upper or lower word when XLEN=64); double uses the full word; misaligned low offset bits are ignored.
REQ-030 ld_size=11 with XLEN=32 behaves as word.
REQ-031 Extension: sign-extend from the loaded MSB unless ld_unsigned; word loads with XLEN=32 pass through unchanged.
REQ-032 rf_we = captured reg_write & (rd!=0); otherwise rf_we=0, and rf_waddr/rf_wdata hold their previous values.
REQ-033 rf_we is a single-cycle pulse per instruction; it deasserts on any cycle with no completion.
REQ-034 Flush in WAIT_MEM (including the same cycle as mem_rvalid): abandon the load, with no write and no count, and go to IDLE next cycle.
REQ-035 retire_cnt increments by 1 per completed instruction regardless of rd or reg_write and wraps modulo 2^CNTW.

Reset
REQ-036 While rst is high: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, retire_cnt=0, busy=0; in_ready=1 after rst deasserts.
REQ-037 Reset in WAIT_MEM discards the load; a later mem_rvalid produces no write.

Structure
REQ-038 Package wb_pkg holds the wb_sel, ld_size and FSM state encodings.
REQ-039 Sub-module wb_load_align is purely combinational and performs lane select and extension (parameter XLEN).

Verification
REQ-040 Reset, then wb_sel=ALU, alu_result=0x000000FF, rd=5, reg_write=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x000000FF, retire_cnt=1.
REQ-041 Signed byte load at offset 3, mem_rdata=0x80FF1234, mem_rvalid 2 cycles later -> in_ready=0 and busy=1 while waiting; rf_wdata=0xFFFFFF80 one cycle after mem_rvalid.
REQ-042 Unsigned half load at offset 2, mem_rdata=0xBEEF0000 -> rf_wdata=0x0000BEEF; same case signed -> 0xFFFFBEEF.
REQ-043 wb_sel=PC+4, rd=0, reg_write=1 -> rf_we=0, retire_cnt increments.
REQ-044 Flush asserted in WAIT_MEM on the same cycle as mem_rvalid -> no rf_we, retire_cnt unchanged, in_ready=1 next cycle.
REQ-045 rst asserted during WAIT_MEM, then mem_rvalid -> all outputs stay 0 and no write occurs.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the write-back stage.
//   wb_sel_e  - result source select
//   ld_size_e - load access size
//   state_e   - stage FSM states
//   ld_ctx_t  - load attributes held while the memory response is pending
package wb_pkg;

   typedef enum logic [1:0] {
      SEL_ALU = 2'b00,
      SEL_MEM = 2'b01,
      SEL_PC4 = 2'b10,
      SEL_IMM = 2'b11
   } wb_sel_e;

   typedef enum logic [1:0] {
      LD_B = 2'b00,
      LD_H = 2'b01,
      LD_W = 2'b10,
      LD_D = 2'b11
   } ld_size_e;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } state_e;

   typedef struct packed {
      logic     we;
      logic     uns;
      ld_size_e size;
   } ld_ctx_t;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational lane select and sign/zero extension of a
// load data word.
//   rdata  - raw memory word
//   offset - byte offset of the access (low address bits)
//   size   - access size (ld_size_e)
//   uns    - 1 = zero-extend, 0 = sign-extend
//   data   - aligned, extended result
module wb_load_align
   import wb_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int OFFW = $clog2(XLEN/8)
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [OFFW-1:0] offset,
   input  ld_size_e        size,
   input  logic            uns,
   output logic [XLEN-1:0] data
);

   logic [OFFW-1:0] off_m;
   logic [OFFW+2:0] sh;
   logic [XLEN-1:0] shifted;
   logic            fill;
   int              w;

   always_comb begin
      off_m = offset;
      w     = 8;
      // Clearing the low offset bits both picks the naturally aligned lane
      // and drops misaligned bits. A double on XLEN=32 collapses to a word.
      case (size)
         LD_B: begin off_m = offset;               w = 8;    end
         LD_H: begin off_m = offset & ~OFFW'(1);   w = 16;   end
         LD_W: begin off_m = offset & ~OFFW'(3);   w = 32;   end
         default: begin off_m = '0;                w = XLEN; end
      endcase
      sh      = {off_m, 3'b000};
      shifted = rdata >> sh;
      case (size)
         LD_B:    fill = ~uns & shifted[7];
         LD_H:    fill = ~uns & shifted[15];
         LD_W:    fill = ~uns & shifted[31];
         default: fill = ~uns & shifted[XLEN-1];
      endcase
      data = shifted;
      // Bits at or above the loaded width get the fill; a full-width load
      // leaves the word untouched.
      for (int i = 8; i < XLEN; i++) begin
         if (i >= w) data[i] = fill;
      end
   end

endmodule

// File: rtl/wb_pipe.sv
// wb_pipe: MEM/WB write-back stage. Non-memory results are registered and
// written one cycle after acceptance; loads park in WAIT_MEM until the
// memory response arrives, then the aligned/extended data is written one
// cycle later.
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - instruction handshake
//   wb_sel, ld_size, ld_unsigned, reg_write, rd - instruction controls
//   alu_result, pc_plus4, imm - result sources (alu_result is load address)
//   mem_rvalid, mem_rdata - load response
//   flush             - kill current/incoming instruction
//   rf_we, rf_waddr, rf_wdata - register-file write port
//   busy              - load outstanding
//   retire_cnt        - completed-instruction counter
module wb_pipe
   import wb_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int RADDR = 5,
   parameter int CNTW  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       wb_sel,
   input  logic [1:0]       ld_size,
   input  logic             ld_unsigned,
   input  logic             reg_write,
   input  logic [RADDR-1:0] rd,
   input  logic [XLEN-1:0]  alu_result,
   input  logic [XLEN-1:0]  pc_plus4,
   input  logic [XLEN-1:0]  imm,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic             flush,
   output logic             rf_we,
   output logic [RADDR-1:0] rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             busy,
   output logic [CNTW-1:0]  retire_cnt
);

   localparam int OFFW = $clog2(XLEN/8);

   state_e           state, state_nxt;
   wb_sel_e          sel;
   ld_ctx_t          ctx;
   logic [RADDR-1:0] ld_rd;
   logic [OFFW-1:0]  ld_off;
   logic             accept, is_mem, done_alu, done_mem, done, wr_now;
   logic [XLEN-1:0]  sel_data, ld_data, wr_data;
   logic [RADDR-1:0] wr_addr;

   assign sel      = wb_sel_e'(wb_sel);
   assign in_ready = (state == IDLE);
   assign busy     = (state == WAIT_MEM);

   wb_load_align #(.XLEN(XLEN), .OFFW(OFFW)) u_align (
      .rdata  (mem_rdata),
      .offset (ld_off),
      .size   (ctx.size),
      .uns    (ctx.uns),
      .data   (ld_data)
   );

   always_comb begin
      accept   = in_valid & in_ready & ~flush;
      is_mem   = (sel == SEL_MEM);
      done_alu = accept & ~is_mem;
      // Flush wins over a same-cycle response: the load is abandoned.
      done_mem = (state == WAIT_MEM) & mem_rvalid & ~flush;
      done     = done_alu | done_mem;

      case (sel)
         SEL_PC4: sel_data = pc_plus4;
         SEL_IMM: sel_data = imm;
         default: sel_data = alu_result;
      endcase

      wr_now  = 1'b0;
      wr_addr = rd;
      wr_data = sel_data;
      if (done_mem) begin
         wr_now  = ctx.we & (ld_rd != '0);
         wr_addr = ld_rd;
         wr_data = ld_data;
      end else if (done_alu) begin
         wr_now  = reg_write & (rd != '0);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept & is_mem)     state_nxt = WAIT_MEM;
         WAIT_MEM: if (flush | mem_rvalid)  state_nxt = IDLE;
         default:                           state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         retire_cnt <= '0;
         ctx        <= '0;
         ld_rd      <= '0;
         ld_off     <= '0;
      end else begin
         state <= state_nxt;
         rf_we <= wr_now;
         // Address/data only move on a real write so they hold otherwise.
         if (wr_now) begin
            rf_waddr <= wr_addr;
            rf_wdata <= wr_data;
         end
         if (done) retire_cnt <= retire_cnt + CNTW'(1);
         if (accept & is_mem) begin
            ctx.we   <= reg_write;
            ctx.uns  <= ld_unsigned;
            ctx.size <= ld_size_e'(ld_size);
            ld_rd    <= rd;
            ld_off   <= alu_result[OFFW-1:0];
         end
      end
   end

endmodule

// File: tb/tb_wb_pipe.sv
module tb_wb_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  wb_sel;
   logic [1:0]  ld_size;
   logic        ld_unsigned;
   logic        reg_write;
   logic [4:0]  rd;
   logic [31:0] alu_result;
   logic [31:0] pc_plus4;
   logic [31:0] imm;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        flush;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        busy;
   logic [31:0] retire_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   wb_pipe #(.XLEN(32), .RADDR(5), .CNTW(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .wb_sel      (wb_sel),
      .ld_size     (ld_size),
      .ld_unsigned (ld_unsigned),
      .reg_write   (reg_write),
      .rd          (rd),
      .alu_result  (alu_result),
      .pc_plus4    (pc_plus4),
      .imm         (imm),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .flush       (flush),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .busy        (busy),
      .retire_cnt  (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] sel, input logic [4:0] r, input logic rw,
                        input logic [31:0] a, input logic [31:0] p, input logic [31:0] i);
      in_valid   = 1'b1;
      wb_sel     = sel;
      rd         = r;
      reg_write  = rw;
      alu_result = a;
      pc_plus4   = p;
      imm        = i;
      tick();
      in_valid   = 1'b0;
   endtask

   // Issue a load, wait lat cycles in WAIT_MEM, return data, check result.
   task automatic load(input string tag, input logic [1:0] sz, input logic un,
                       input logic [31:0] addr, input logic [4:0] r,
                       input logic [31:0] data, input int lat, input logic [31:0] exp);
      ld_size     = sz;
      ld_unsigned = un;
      issue(2'b01, r, 1'b1, addr, 32'h0, 32'h0);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_ready"}, in_ready, 1'b0);
      repeat (lat) tick();
      chk({tag, "_still_busy"}, busy, 1'b1);
      mem_rvalid = 1'b1;
      mem_rdata  = data;
      tick();
      mem_rvalid = 1'b0;
      exp_cnt++;
      chk({tag, "_we"}, rf_we, 1'b1);
      chk({tag, "_waddr"}, rf_waddr, r);
      chk({tag, "_wdata"}, rf_wdata, exp);
      chk({tag, "_cnt"}, retire_cnt, exp_cnt);
      chk({tag, "_ready_after"}, in_ready, 1'b1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; wb_sel = 2'b00; ld_size = 2'b00; ld_unsigned = 1'b0;
      reg_write = 1'b0; rd = '0; alu_result = '0; pc_plus4 = '0; imm = '0;
      mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_we", rf_we, 1'b0);
      chk("rst_waddr", rf_waddr, 5'd0);
      chk("rst_wdata", rf_wdata, 32'h0);
      chk("rst_cnt", retire_cnt, 32'h0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick();
      chk("rst_ready", in_ready, 1'b1);

      // ALU write
      issue(2'b00, 5'd5, 1'b1, 32'h0000_00FF, 32'h0, 32'h0);
      exp_cnt++;
      chk("alu_we", rf_we, 1'b1);
      chk("alu_waddr", rf_waddr, 5'd5);
      chk("alu_wdata", rf_wdata, 32'h0000_00FF);
      chk("alu_cnt", retire_cnt, exp_cnt);

      // Back-to-back IMM then ALU
      in_valid = 1'b1; wb_sel = 2'b11; rd = 5'd7; reg_write = 1'b1; imm = 32'h0000_1234;
      tick();
      exp_cnt++;
      chk("b2b_imm_we", rf_we, 1'b1);
      chk("b2b_imm_wdata", rf_wdata, 32'h0000_1234);
      wb_sel = 2'b00; rd = 5'd8; alu_result = 32'hAAAA_5555;
      tick();
      in_valid = 1'b0;
      exp_cnt++;
      chk("b2b_alu_we", rf_we, 1'b1);
      chk("b2b_alu_waddr", rf_waddr, 5'd8);
      chk("b2b_alu_wdata", rf_wdata, 32'hAAAA_5555);
      chk("b2b_cnt", retire_cnt, exp_cnt);
      tick();
      chk("pulse_drop", rf_we, 1'b0);

      // Loads
      load("lb_s3",  2'b00, 1'b0, 32'h0000_0103, 5'd9,  32'h80FF_1234, 2, 32'hFFFF_FF80);
      load("lhu_2",  2'b01, 1'b1, 32'h0000_0002, 5'd10, 32'hBEEF_0000, 0, 32'h0000_BEEF);
      load("lh_2",   2'b01, 1'b0, 32'h0000_0002, 5'd11, 32'hBEEF_0000, 1, 32'hFFFF_BEEF);
      load("lbu_1",  2'b00, 1'b1, 32'h0000_0001, 5'd12, 32'h80FF_1234, 0, 32'h0000_0012);
      load("lb_2",   2'b00, 1'b0, 32'h0000_0002, 5'd13, 32'h80FF_1234, 0, 32'hFFFF_FFFF);
      load("lw_mis", 2'b10, 1'b0, 32'h0000_0001, 5'd14, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
      load("ld_32",  2'b11, 1'b0, 32'h0000_0000, 5'd15, 32'h8765_4321, 0, 32'h8765_4321);
      load("lh_mis", 2'b01, 1'b1, 32'h0000_0003, 5'd16, 32'hBEEF_0000, 0, 32'h0000_BEEF);

      // mem_rvalid in IDLE is ignored
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      tick();
      mem_rvalid = 1'b0;
      chk("idle_rvalid_we", rf_we, 1'b0);
      chk("idle_rvalid_cnt", retire_cnt, exp_cnt);

      // PC+4 to x0: counts, no write, data holds
      issue(2'b10, 5'd0, 1'b1, 32'h0, 32'h0000_1004, 32'h0);
      exp_cnt++;
      chk("x0_we", rf_we, 1'b0);
      chk("x0_cnt", retire_cnt, exp_cnt);
      chk("x0_hold", rf_wdata, 32'h0000_BEEF);

      // reg_write=0: counts, no write
      issue(2'b00, 5'd3, 1'b0, 32'h5A5A_5A5A, 32'h0, 32'h0);
      exp_cnt++;
      chk("nowr_we", rf_we, 1'b0);
      chk("nowr_cnt", retire_cnt, exp_cnt);

      // Flush in IDLE drops instruction
      flush = 1'b1;
      issue(2'b00, 5'd4, 1'b1, 32'h0BAD_0BAD, 32'h0, 32'h0);
      flush = 1'b0;
      chk("flush_idle_we", rf_we, 1'b0);
      chk("flush_idle_cnt", retire_cnt, exp_cnt);
      chk("flush_idle_busy", busy, 1'b0);

      // Flush in WAIT_MEM together with mem_rvalid
      ld_size = 2'b10; ld_unsigned = 1'b0;
      issue(2'b01, 5'd6, 1'b1, 32'h0, 32'h0, 32'h0);
      chk("flush_wait_busy", busy, 1'b1);
      flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      flush = 1'b0; mem_rvalid = 1'b0;
      chk("flush_wait_we", rf_we, 1'b0);
      chk("flush_wait_cnt", retire_cnt, exp_cnt);
      chk("flush_wait_ready", in_ready, 1'b1);
      tick();
      chk("flush_wait_we2", rf_we, 1'b0);

      // Reset during WAIT_MEM, then a stale mem_rvalid
      issue(2'b01, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0);
      chk("rstw_busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      exp_cnt = 0;
      chk("rstw_we", rf_we, 1'b0);
      chk("rstw_waddr", rf_waddr, 5'd0);
      chk("rstw_wdata", rf_wdata, 32'h0);
      chk("rstw_cnt", retire_cnt, exp_cnt);
      chk("rstw_busy0", busy, 1'b0);
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_rvalid = 1'b0;
      chk("rstw_stale_we", rf_we, 1'b0);
      chk("rstw_stale_wdata", rf_wdata, 32'h0);
      chk("rstw_stale_cnt", retire_cnt, exp_cnt);
      chk("rstw_ready", in_ready, 1'b1);
      tick();
      chk("rstw_stale_we2", rf_we, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
